// File: rtl/conv_control.sv
// conv_control
//   Loop-nest sequencer for a 2-D convolution engine. It walks the output
//   pixel position (k row, j column), the input channel (l) and the kernel
//   window (n row, m column). It advances one step on each clock edge where
//   en_ctrl is high, and it emits the signed input-image coordinate to fetch.
//
// Ports
//   clk      in   rising-edge clock
//   reset    in   asynchronous, active-low reset
//   en_ctrl  in   run/advance enable (level)
//   i        out  linear output-pixel index, 0..OUT_W*OUT_H-1
//   j, k     out  output column / row
//   m, n     out  kernel column / row
//   l        out  input channel
//   finish   out  sweep complete (registered)
//   in_row   out  signed input row    = k + n - PAD (combinational)
//   in_col   out  signed input column = j + m - PAD (combinational)
//   in_valid out  only when CONV_CTRL_BOUNDS_EN is defined. It is high while
//                 RUN and the coordinate lies inside the image.
//
// Optional feature macro: CONV_CTRL_BOUNDS_EN
module conv_control #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int K_W   = 3,
    parameter int K_H   = 3,
    parameter int CH    = 1,
    parameter int PAD   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en_ctrl,
    output logic        [7:0] i,
    output logic        [7:0] j,
    output logic        [7:0] k,
    output logic        [7:0] m,
    output logic        [7:0] n,
    output logic        [1:0] l,
    output logic              finish,
    output logic signed [7:0] in_row,
    output logic signed [7:0] in_col
`ifdef CONV_CTRL_BOUNDS_EN
    ,
    output logic              in_valid
`endif
);

    localparam int OUT_W = IMG_W + 2 * PAD - K_W + 1;
    localparam int OUT_H = IMG_H + 2 * PAD - K_H + 1;

    localparam logic [7:0] M_MAX = 8'(K_W - 1);
    localparam logic [7:0] N_MAX = 8'(K_H - 1);
    localparam logic [1:0] L_MAX = 2'(CH - 1);
    localparam logic [7:0] J_MAX = 8'(OUT_W - 1);
    localparam logic [7:0] I_MAX = 8'(OUT_W * OUT_H - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] i_q, i_d;
    logic [7:0] j_q, j_d;
    logic [7:0] k_q, k_d;
    logic [7:0] m_q, m_d;
    logic [7:0] n_q, n_d;
    logic [1:0] l_q, l_d;
    logic       finish_q, finish_d;

    logic m_wrap, n_wrap, l_wrap, j_wrap, pix_end, last_iter;

    assign m_wrap    = (m_q == M_MAX);
    assign n_wrap    = (n_q == N_MAX);
    assign l_wrap    = (l_q == L_MAX);
    assign j_wrap    = (j_q == J_MAX);
    // The kernel window and all channels for this output pixel are consumed.
    assign pix_end   = m_wrap && n_wrap && l_wrap;
    // i reaches its maximum only on the last pixel, so k and j are at their
    // maximums too.
    assign last_iter = pix_end && (i_q == I_MAX);

    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        j_d      = j_q;
        k_d      = k_q;
        m_d      = m_q;
        n_d      = n_q;
        l_d      = l_q;
        finish_d = finish_q;

        unique case (state_q)
            IDLE: begin
                i_d      = '0;
                j_d      = '0;
                k_d      = '0;
                m_d      = '0;
                n_d      = '0;
                l_d      = '0;
                finish_d = 1'b0;
                // The edge that starts RUN does not advance, so the first
                // iteration is all-zero.
                if (en_ctrl) state_d = RUN;
            end
            RUN: begin
                if (en_ctrl) begin
                    if (last_iter) begin
                        // Counters hold their final values; they do not wrap.
                        state_d  = DONE;
                        finish_d = 1'b1;
                    end else begin
                        m_d = m_wrap ? '0 : m_q + 8'd1;
                        if (m_wrap) n_d = n_wrap ? '0 : n_q + 8'd1;
                        if (m_wrap && n_wrap) l_d = l_wrap ? '0 : l_q + 2'd1;
                        if (pix_end) begin
                            i_d = i_q + 8'd1;
                            j_d = j_wrap ? '0 : j_q + 8'd1;
                            if (j_wrap) k_d = k_q + 8'd1;
                        end
                    end
                end
            end
            DONE: begin
                finish_d = 1'b1;
                if (!en_ctrl) begin
                    state_d  = IDLE;
                    i_d      = '0;
                    j_d      = '0;
                    k_d      = '0;
                    m_d      = '0;
                    n_d      = '0;
                    l_d      = '0;
                    finish_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            m_q      <= '0;
            n_q      <= '0;
            l_q      <= '0;
            finish_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            i_q      <= i_d;
            j_q      <= j_d;
            k_q      <= k_d;
            m_q      <= m_d;
            n_q      <= n_d;
            l_q      <= l_d;
            finish_q <= finish_d;
        end
    end

    assign i      = i_q;
    assign j      = j_q;
    assign k      = k_q;
    assign m      = m_q;
    assign n      = n_q;
    assign l      = l_q;
    assign finish = finish_q;

    // Modulo-256 arithmetic gives the two's complement coordinate. It is
    // negative inside the top/left padding.
    assign in_row = $signed(k_q + n_q - 8'(PAD));
    assign in_col = $signed(j_q + m_q - 8'(PAD));

`ifdef CONV_CTRL_BOUNDS_EN
    // A clear sign bit makes the unsigned compare equal to the signed range test.
    assign in_valid = (state_q == RUN) &&
                      !in_row[7] && ($unsigned(in_row) < 8'(IMG_H)) &&
                      !in_col[7] && ($unsigned(in_col) < 8'(IMG_W));
`endif

endmodule

// File: tb/tb_conv_control.sv
// Testbench for conv_control. It runs two configurations side by side:
//   dut0: defaults (8x8 image, 3x3 kernel, CH=1, PAD=1)
//   dut1: 4x4 image, 3x3 kernel, CH=2, PAD=0
// The reference model precomputes the full iteration sequence from nested
// loops. Expected snapshots are queued per cycle, and a monitor compares
// them on the falling edge.
module tb_conv_control;

    localparam int IW [2] = '{8, 4};
    localparam int IH [2] = '{8, 4};
    localparam int KW [2] = '{3, 3};
    localparam int KH [2] = '{3, 3};
    localparam int NC [2] = '{1, 2};
    localparam int PD [2] = '{1, 0};

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic en_ctrl = 1'b0;

    logic [7:0] i_a, j_a, k_a, m_a, n_a, i_b, j_b, k_b, m_b, n_b;
    logic [1:0] l_a, l_b;
    logic       fin_a, fin_b;
    logic signed [7:0] row_a, col_a, row_b, col_b;
`ifdef CONV_CTRL_BOUNDS_EN
    logic vld_a, vld_b;
`endif

    always #5 clk = ~clk;

    conv_control u_dut0 (
        .clk(clk), .reset(reset), .en_ctrl(en_ctrl),
        .i(i_a), .j(j_a), .k(k_a), .m(m_a), .n(n_a), .l(l_a),
        .finish(fin_a), .in_row(row_a), .in_col(col_a)
`ifdef CONV_CTRL_BOUNDS_EN
        , .in_valid(vld_a)
`endif
    );

    conv_control #(
        .IMG_W(4), .IMG_H(4), .K_W(3), .K_H(3), .CH(2), .PAD(0)
    ) u_dut1 (
        .clk(clk), .reset(reset), .en_ctrl(en_ctrl),
        .i(i_b), .j(j_b), .k(k_b), .m(m_b), .n(n_b), .l(l_b),
        .finish(fin_b), .in_row(row_b), .in_col(col_b)
`ifdef CONV_CTRL_BOUNDS_EN
        , .in_valid(vld_b)
`endif
    );

    typedef struct {
        int i, j, k, m, n, l;
    } iter_t;

    typedef struct {
        int i, j, k, m, n, l, fin, row, col, vld;
    } snap_t;

    iter_t seq_q [2][$];
    snap_t exp_q [2][$];
    int    ph    [2];   // 0 idle, 1 running, 2 done
    int    idx   [2];

    int checks = 0;
    int errors = 0;

    task automatic cmp(input string name, input int c, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s dut%0d t=%0t: got %0d expected %0d", name, c, $time, act, exp);
        end
    endtask

    // Reference sequence: loop nest k, j, l, n, m with m innermost.
    task automatic build(input int c);
        int ow, oh;
        iter_t it;
        ow = IW[c] + 2 * PD[c] - KW[c] + 1;
        oh = IH[c] + 2 * PD[c] - KH[c] + 1;
        for (int kk = 0; kk < oh; kk++)
            for (int jj = 0; jj < ow; jj++)
                for (int ll = 0; ll < NC[c]; ll++)
                    for (int nn = 0; nn < KH[c]; nn++)
                        for (int mm = 0; mm < KW[c]; mm++) begin
                            it.i = kk * ow + jj; it.j = jj; it.k = kk;
                            it.m = mm; it.n = nn; it.l = ll;
                            seq_q[c].push_back(it);
                        end
    endtask

    function automatic snap_t expect_of(input int c);
        snap_t s;
        iter_t it;
        it = '{0, 0, 0, 0, 0, 0};
        if (ph[c] == 1) it = seq_q[c][idx[c]];
        if (ph[c] == 2) it = seq_q[c][seq_q[c].size() - 1];
        s.i = it.i; s.j = it.j; s.k = it.k; s.m = it.m; s.n = it.n; s.l = it.l;
        s.fin = (ph[c] == 2) ? 1 : 0;
        s.row = it.k + it.n - PD[c];
        s.col = it.j + it.m - PD[c];
        s.vld = (ph[c] == 1 && s.row >= 0 && s.row < IH[c] &&
                 s.col >= 0 && s.col < IW[c]) ? 1 : 0;
        return s;
    endfunction

    function automatic snap_t actual_of(input int c);
        snap_t s;
        s.vld = 0;
        if (c == 0) begin
            s.i = int'(i_a); s.j = int'(j_a); s.k = int'(k_a); s.m = int'(m_a);
            s.n = int'(n_a); s.l = int'(l_a); s.fin = int'(fin_a);
            s.row = int'(row_a); s.col = int'(col_a);
`ifdef CONV_CTRL_BOUNDS_EN
            s.vld = int'(vld_a);
`endif
        end else begin
            s.i = int'(i_b); s.j = int'(j_b); s.k = int'(k_b); s.m = int'(m_b);
            s.n = int'(n_b); s.l = int'(l_b); s.fin = int'(fin_b);
            s.row = int'(row_b); s.col = int'(col_b);
`ifdef CONV_CTRL_BOUNDS_EN
            s.vld = int'(vld_b);
`endif
        end
        return s;
    endfunction

    task automatic model_edge(input int c, input bit en);
        case (ph[c])
            0: if (en) begin ph[c] = 1; idx[c] = 0; end
            1: if (en) begin
                if (idx[c] == seq_q[c].size() - 1) ph[c] = 2;
                else idx[c]++;
            end
            default: if (!en) ph[c] = 0;
        endcase
    endtask

    // One clock: update the model for the edge, then change the inputs
    // 1ns later and queue what each DUT should show for the rest of the cycle.
    task automatic tick(input bit new_rst, input bit new_en);
        @(posedge clk);
        for (int c = 0; c < 2; c++)
            if (reset) model_edge(c, en_ctrl);
        #1;
        reset = new_rst;
        en_ctrl = new_en;
        for (int c = 0; c < 2; c++) begin
            if (!new_rst) begin ph[c] = 0; idx[c] = 0; end
            exp_q[c].push_back(expect_of(c));
        end
    endtask

    // Monitor: compare each queued snapshot on the falling edge.
    initial begin
        snap_t e, a;
        forever begin
            @(negedge clk);
            for (int c = 0; c < 2; c++) begin
                if (exp_q[c].size() > 0) begin
                    e = exp_q[c].pop_front();
                    a = actual_of(c);
                    cmp("i", c, a.i, e.i);
                    cmp("j", c, a.j, e.j);
                    cmp("k", c, a.k, e.k);
                    cmp("m", c, a.m, e.m);
                    cmp("n", c, a.n, e.n);
                    cmp("l", c, a.l, e.l);
                    cmp("finish", c, a.fin, e.fin);
                    cmp("in_row", c, a.row, e.row);
                    cmp("in_col", c, a.col, e.col);
`ifdef CONV_CTRL_BOUNDS_EN
                    cmp("in_valid", c, a.vld, e.vld);
`endif
                end
            end
        end
    end

    initial begin
        int cnt;
        int run_len;
        bit en;
        for (int c = 0; c < 2; c++) begin
            build(c);
            ph[c] = 0;
            idx[c] = 0;
        end

        // Hold reset, then release it while idle.
        tick(0, 0);
        tick(0, 0);
        tick(1, 0);
        tick(1, 0);

        // Full sweep with en_ctrl held high. Count edges from start to finish.
        tick(1, 1);
        cnt = 0;
        while (cnt < 2000) begin
            tick(1, 1);
            cnt++;
            if (fin_a) break;
        end
        cmp("finish_latency", 0, cnt, 577);
        tick(1, 1);
        tick(1, 1);
        tick(1, 1);
        tick(1, 0);
        tick(1, 0);

        // Random enable pattern with a forced 5-cycle pause.
        cnt = 0;
        tick(1, 1);
        while (ph[0] != 2 && cnt < 4000) begin
            if (cnt >= 100 && cnt < 105) en = 1'b0;
            else en = ($urandom_range(0, 99) < 80);
            tick(1, en);
            cnt++;
        end
        cmp("random_sweep_done", 0, ph[0], 2);
        tick(1, 0);
        tick(1, 0);

        // Asynchronous reset mid-run, then a complete repeat sweep.
        run_len = $urandom_range(50, 300);
        for (int t = 0; t < run_len; t++) tick(1, 1);
        tick(0, 1);
        tick(0, 1);
        tick(1, 0);
        tick(1, 1);
        cnt = 0;
        while (ph[0] != 2 && cnt < 2000) begin
            tick(1, 1);
            cnt++;
        end
        cmp("post_reset_sweep_done", 0, ph[0], 2);
        tick(1, 1);
        tick(1, 0);
        tick(1, 0);

        @(posedge clk);
        @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
